// File: rtl/usb_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_ctrl
// Brief    : USB 1.1 full-speed receive control: SYNC check, byte assembly,
//            FIFO write pulses and EOP handling. Optional PID check enabled by
//            defining USB_RX_PID_CHECK_EN.
// Revision : 1.0
// ============================================================================
module usb_rx_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             d_orig,
  input  logic             shift_enable,
  input  logic             eop,
  output logic             rcving,
  output logic             w_enable,
  output logic [7:0]       rcv_data,
  output logic             r_error,
  output logic [CNT_W-1:0] pkt_bytes
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SYNC     = 3'd1,
    S_RCV      = 3'd2,
    S_ERR      = 3'd3,
    S_EOP_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_MAX_BYTES = CNT_W'(MAX_BYTES);

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;

  logic       w_bit;
  logic       w_se0;
  logic       w_byte_done;
  logic       w_pid_bad;
  logic [7:0] w_shift_next;

  // SE0 on a strobe outranks the data bit
  assign w_bit        = shift_enable && !eop;
  assign w_se0        = shift_enable && eop;
  assign w_byte_done  = w_bit && (r_bit_cnt == 3'd7);
  assign w_shift_next = {d_orig, r_shift[7:1]};

`ifdef USB_RX_PID_CHECK_EN
  assign w_pid_bad = (pkt_bytes == '0) && (w_shift_next[7:4] != ~w_shift_next[3:0]);
`else
  assign w_pid_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      rcving    <= 1'b0;
      w_enable  <= 1'b0;
      rcv_data  <= 8'h00;
      r_error   <= 1'b0;
      pkt_bytes <= '0;
    end else begin
      w_enable <= 1'b0;
      if (r_state != S_IDLE && w_bit) begin
        r_shift   <= w_shift_next;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (d_edge) begin
            r_error   <= 1'b0;
            pkt_bytes <= '0;
            r_bit_cnt <= 3'd0;
            rcving    <= 1'b1;
            r_state   <= S_SYNC;
          end
        end
        S_SYNC: begin
          if (w_se0) begin
            r_error <= 1'b1;
            r_state <= S_EOP_WAIT;
          end else if (w_byte_done) begin
            if (w_shift_next == SYNC_BYTE) begin
              r_state <= S_RCV;
            end else begin
              r_error <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_RCV: begin
          if (w_se0) begin
            // SE0 mid-byte leaves a truncated byte behind
            if (r_bit_cnt != 3'd0) begin
              r_error <= 1'b1;
            end
            r_state <= S_EOP_WAIT;
          end else if (w_byte_done) begin
            if (pkt_bytes == c_MAX_BYTES || w_pid_bad) begin
              r_error <= 1'b1;
              r_state <= S_ERR;
            end else begin
              rcv_data  <= w_shift_next;
              w_enable  <= 1'b1;
              pkt_bytes <= pkt_bytes + CNT_W'(1);
            end
          end
        end
        S_ERR: begin
          if (w_se0) begin
            r_state <= S_EOP_WAIT;
          end
        end
        S_EOP_WAIT: begin
          if (w_bit) begin
            rcving  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          rcving  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_ctrl
// Brief    : Self-checking bench for usb_rx_ctrl: packet table, corner-case
//            sequences and random packets against a packet-level model.
// Revision : 1.0
// ============================================================================
module tb_usb_rx_ctrl;

  localparam int MAXB = 64;
  localparam int CW   = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_edge;
  logic          d_orig;
  logic          shift_enable;
  logic          eop;
  logic          rcving;
  logic          w_enable;
  logic [7:0]    rcv_data;
  logic          r_error;
  logic [CW-1:0] pkt_bytes;

  usb_rx_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .d_orig(d_orig),
    .shift_enable(shift_enable), .eop(eop), .rcving(rcving),
    .w_enable(w_enable), .rcv_data(rcv_data), .r_error(r_error),
    .pkt_bytes(pkt_bytes)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  int         dbl_cnt = 0;
  logic       prev_we = 1'b0;

  always @(negedge clk) begin
    if (w_enable) begin
      got.push_back(rcv_data);
      if (prev_we) dbl_cnt <= dbl_cnt + 1;
    end
    prev_we <= w_enable;
  end

  typedef struct {
    logic [7:0]  sync;
    int          n;
    logic [31:0] d;
    int          part;
    int          nw;
    logic        err;
  } vec_t;

  vec_t       tbl[8];
  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic       exp_err;
  int         start_idx;
  int         start_dbl;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic strobe(input logic b, input logic e);
    @(negedge clk);
    d_orig = b; eop = e; shift_enable = 1'b1;
    @(negedge clk);
    shift_enable = 1'b0; eop = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) strobe(v[i], 1'b0);
  endtask

  task automatic pulse_edge();
    @(negedge clk);
    d_edge = 1'b1;
    @(negedge clk);
    d_edge = 1'b0;
  endtask

  task automatic finish_eop(input string nm);
    strobe(1'b0, 1'b1);
    strobe(1'b0, 1'b1);
    chk({nm, " rcving_in_se0"}, int'(rcving), 1);
    strobe(1'b1, 1'b0);
    chk({nm, " rcving_after_j"}, int'(rcving), 0);
  endtask

  task automatic begin_packet(input string nm);
    start_idx = got.size();
    start_dbl = dbl_cnt;
    pulse_edge();
    chk({nm, " rcving_start"}, int'(rcving), 1);
    chk({nm, " err_cleared"}, int'(r_error), 0);
    chk({nm, " pkt_cleared"}, int'(pkt_bytes), 0);
  endtask

  task automatic send_packet(input string nm, input logic [7:0] sync, input int part);
    begin_packet(nm);
    send_byte(sync);
    foreach (tx_q[i]) send_byte(tx_q[i]);
    for (int i = 0; i < part; i++) strobe(1'($urandom_range(0, 1)), 1'b0);
    finish_eop(nm);
  endtask

  task automatic check_result(input string nm);
    chk({nm, " writes"}, got.size() - start_idx, exp_q.size());
    foreach (exp_q[i]) begin
      if (start_idx + i < got.size())
        chk({nm, " data"}, int'(got[start_idx + i]), int'(exp_q[i]));
    end
    chk({nm, " r_error"}, int'(r_error), int'(exp_err));
    chk({nm, " pkt_bytes"}, int'(pkt_bytes), exp_q.size());
    chk({nm, " we_width"}, dbl_cnt - start_dbl, 0);
  endtask

  // Packet-level reference: which bytes reach the FIFO and whether the packet is flagged
  task automatic model(input logic [7:0] sync, input int part);
    exp_q.delete();
    exp_err = 1'b0;
    if (sync != 8'h80) begin
      exp_err = 1'b1;
      return;
    end
    foreach (tx_q[i]) begin
      if (exp_q.size() == MAXB) begin
        exp_err = 1'b1;
        return;
      end
`ifdef USB_RX_PID_CHECK_EN
      if (i == 0 && tx_q[0][7:4] != ~tx_q[0][3:0]) begin
        exp_err = 1'b1;
        return;
      end
`endif
      exp_q.push_back(tx_q[i]);
    end
    if (part != 0) exp_err = 1'b1;
  endtask

  initial begin
    tbl[0] = '{8'h80, 2, 32'h0000_A5C3, 0, 2, 1'b0};
    tbl[1] = '{8'h81, 0, 32'h0000_0000, 0, 0, 1'b1};
    tbl[2] = '{8'h80, 1, 32'h0000_003C, 5, 1, 1'b1};
    tbl[3] = '{8'h80, 0, 32'h0000_0000, 0, 0, 1'b0};
`ifdef USB_RX_PID_CHECK_EN
    tbl[4] = '{8'h80, 1, 32'h0000_00C4, 0, 0, 1'b1};
`else
    tbl[4] = '{8'h80, 1, 32'h0000_00C4, 0, 1, 1'b0};
`endif
    tbl[5] = '{8'h80, 4, 32'hFF00_5AE1, 0, 4, 1'b0};
    tbl[6] = '{8'h80, 3, 32'h0033_77D2, 7, 3, 1'b1};
    tbl[7] = '{8'h00, 2, 32'h0000_1234, 0, 0, 1'b1};

    rst = 1'b1; d_edge = 1'b0; d_orig = 1'b0; shift_enable = 1'b0; eop = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rcving", int'(rcving), 0);
    chk("reset w_enable", int'(w_enable), 0);
    chk("reset rcv_data", int'(rcv_data), 0);
    chk("reset r_error", int'(r_error), 0);
    chk("reset pkt_bytes", int'(pkt_bytes), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (tbl[k]) begin
      tx_q.delete();
      exp_q.delete();
      for (int i = 0; i < tbl[k].n; i++) tx_q.push_back(tbl[k].d[8*i +: 8]);
      for (int i = 0; i < tbl[k].nw; i++) exp_q.push_back(tbl[k].d[8*i +: 8]);
      exp_err = tbl[k].err;
      send_packet($sformatf("tbl%0d", k), tbl[k].sync, tbl[k].part);
      check_result($sformatf("tbl%0d", k));
    end

    // Latency, pulse width and a stray d_edge inside a byte
    begin_packet("lat");
    send_byte(8'h80);
    for (int i = 0; i < 4; i++) strobe(1'(8'hC3 >> i), 1'b0);
    pulse_edge();
    for (int i = 4; i < 8; i++) strobe(1'(8'hC3 >> i), 1'b0);
    chk("lat w_enable", int'(w_enable), 1);
    chk("lat rcv_data", int'(rcv_data), 8'hC3);
    @(negedge clk);
    chk("lat we_low", int'(w_enable), 0);
    chk("lat hold", int'(rcv_data), 8'hC3);
    finish_eop("lat");
    exp_q = '{8'hC3};
    exp_err = 1'b0;
    check_result("lat");

    // SE0 during SYNC
    begin_packet("sync_eop");
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0);
    finish_eop("sync_eop");
    exp_q.delete();
    exp_err = 1'b1;
    check_result("sync_eop");

    // Reset mid-packet aborts with no write and no error
    begin_packet("rst");
    send_byte(8'h80);
    send_byte(8'hE1);
    for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
    start_idx = got.size();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst rcving", int'(rcving), 0);
    chk("rst w_enable", int'(w_enable), 0);
    chk("rst rcv_data", int'(rcv_data), 0);
    chk("rst r_error", int'(r_error), 0);
    chk("rst pkt_bytes", int'(pkt_bytes), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst no_write", got.size() - start_idx, 0);
    tx_q = '{8'hC3, 8'hA5};
    model(8'h80, 0);
    send_packet("post_rst", 8'h80, 0);
    check_result("post_rst");

    // One byte beyond the packet limit
    tx_q = '{8'hE1};
    for (int i = 0; i < MAXB; i++) tx_q.push_back(8'($urandom));
    model(8'h80, 0);
    send_packet("ovf", 8'h80, 0);
    check_result("ovf");
    chk("ovf sat", int'(pkt_bytes), MAXB);

    for (int p = 0; p < 40; p++) begin
      logic [7:0] sync;
      int         n;
      int         part;
      sync = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h80;
      n    = $urandom_range(0, 5);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      tx_q.delete();
      for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
      if (n > 0 && $urandom_range(0, 1) == 1) tx_q[0] = {~tx_q[0][3:0], tx_q[0][3:0]};
      model(sync, part);
      send_packet($sformatf("rnd%0d", p), sync, part);
      check_result($sformatf("rnd%0d", p));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
